// File: rtl/exec_trace_buffer_if.sv
// Trace record stream between exec_trace_buffer (master) and its consumer (slave).
// Record width is 34 bits, or 50 bits when TRACE_CYCLE_STAMP_EN is defined
// (the extra top 16 bits carry the capture-time cycle stamp).
interface exec_trace_buffer_if;
`ifdef TRACE_CYCLE_STAMP_EN
    localparam int TW = 50;
`else
    localparam int TW = 34;
`endif

    logic          trace_valid;
    logic          trace_ready;
    logic [TW-1:0] trace_data;

    modport master (output trace_valid, output trace_data, input trace_ready);
    modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/exec_trace_buffer.sv
// Execution trace buffer for the 8-bit single-cycle processor.
// Turns register write-backs and stores into trace records, queues them in a
// DEPTH-entry FIFO drained over a valid/ready stream, and detects program
// termination (PC unchanged for HALT_CYCLES capture cycles), after which it
// emits one halt marker and stops capturing.
// Optional macro TRACE_CYCLE_STAMP_EN widens records to 50 bits with the
// cycle_count value at capture in bits [49:34].
module exec_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        trace_en,
    input  logic [7:0]                  pc,
    input  logic [7:0]                  inst,
    input  logic                        reg_write,
    input  logic [7:0]                  wdata_reg,
    input  logic                        mem_write,
    input  logic [7:0]                  mem_addr,
    input  logic [7:0]                  mem_wdata,
    exec_trace_buffer_if.master         trace,
    output logic                        halted,
    output logic [7:0]                  overflow_cnt,
    output logic [15:0]                 cycle_count
);

`ifdef TRACE_CYCLE_STAMP_EN
    localparam int TW = 50;
`else
    localparam int TW = 34;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MARK = 2'd1,
        S_DONE = 2'd2
    } haltState_t;

    haltState_t     state_q, state_d;
    logic [TW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     prevPc_q, prevPc_d;
    logic           prevPcValid_q, prevPcValid_d;
    logic [7:0]     stableCnt_q, stableCnt_d;
    logic [7:0]     haltInst_q, haltInst_d;
    logic [7:0]     overflow_q, overflow_d;
    logic [15:0]    cycle_q, cycle_d;

    logic           outValid;
    logic           pop;
    logic           hasSpace;
    logic           push;
    logic [33:0]    recBody;
    logic [TW-1:0]  pushRec;

    assign outValid           = (count_q != '0);
    assign pop                = outValid && trace.trace_ready;
    assign hasSpace           = (count_q != CW'(DEPTH)) || pop;
    assign trace.trace_valid  = outValid;
    assign trace.trace_data   = outValid ? mem_q[rdPtr_q] : '0;
    assign halted             = (state_q != S_RUN);
    assign overflow_cnt       = overflow_q;
    assign cycle_count        = cycle_q;

`ifdef TRACE_CYCLE_STAMP_EN
    assign pushRec = {cycle_q, recBody};
`else
    assign pushRec = recBody;
`endif

    // Capture, halt detection and FIFO bookkeeping; the halt FSM only advances
    // RUN -> MARK -> DONE, so exactly one marker is produced per reset.
    always_comb begin
        state_d       = state_q;
        prevPc_d      = prevPc_q;
        prevPcValid_d = prevPcValid_q;
        stableCnt_d   = stableCnt_q;
        haltInst_d    = haltInst_q;
        overflow_d    = overflow_q;
        cycle_d       = cycle_q;
        push          = 1'b0;
        recBody       = '0;

        case (state_q)
            S_RUN: begin
                if (trace_en) begin
                    cycle_d       = cycle_q + 16'd1;
                    prevPc_d      = pc;
                    prevPcValid_d = 1'b1;
                    if (prevPcValid_q && (pc == prevPc_q)) begin
                        stableCnt_d = (stableCnt_q == 8'(HALT_CYCLES)) ?
                                      stableCnt_q : stableCnt_q + 8'd1;
                    end else begin
                        stableCnt_d = 8'd0;
                    end
                    if (stableCnt_d == 8'(HALT_CYCLES)) begin
                        state_d    = S_MARK;
                        haltInst_d = inst;
                    end
                    if (mem_write || reg_write) begin
                        recBody = mem_write ? {2'b10, pc, inst, mem_addr, mem_wdata}
                                            : {2'b01, pc, inst, 8'h00, wdata_reg};
                        if (hasSpace) begin
                            push = 1'b1;
                        end else if (overflow_q != 8'hFF) begin
                            overflow_d = overflow_q + 8'd1;
                        end
                    end
                end
            end
            S_MARK: begin
                recBody = {2'b11, prevPc_q, haltInst_q, cycle_q[7:0], overflow_q};
                if (hasSpace) begin
                    push    = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
            end
        endcase

        wrPtr_d = wrPtr_q + PW'(push);
        rdPtr_d = rdPtr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // State and counter registers, cleared asynchronously so the stream drops at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            prevPc_q      <= '0;
            prevPcValid_q <= 1'b0;
            stableCnt_q   <= '0;
            haltInst_q    <= '0;
            overflow_q    <= '0;
            cycle_q       <= '0;
        end else begin
            state_q       <= state_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            prevPc_q      <= prevPc_d;
            prevPcValid_q <= prevPcValid_d;
            stableCnt_q   <= stableCnt_d;
            haltInst_q    <= haltInst_d;
            overflow_q    <= overflow_d;
            cycle_q       <= cycle_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wrPtr_q] <= pushRec;
        end
    end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed testbench for exec_trace_buffer (DEPTH=16, HALT_CYCLES=4).
// Compares the low 34 record bits, so it also applies to the stamped build.
module tb_exec_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        trace_en;
    logic [7:0]  pc, inst, wdata_reg, mem_addr, mem_wdata;
    logic        reg_write, mem_write;
    logic        ready;
    logic        halted;
    logic [7:0]  overflow_cnt;
    logic [15:0] cycle_count;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    exec_trace_buffer_if tif ();
    assign tif.trace_ready = ready;

    exec_trace_buffer #(.DEPTH(16), .HALT_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .trace_en     (trace_en),
        .pc           (pc),
        .inst         (inst),
        .reg_write    (reg_write),
        .wdata_reg    (wdata_reg),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .trace        (tif),
        .halted       (halted),
        .overflow_cnt (overflow_cnt),
        .cycle_count  (cycle_count)
    );

    // 100 MHz-style free-running clock
    always #5 clock = ~clock;

    function automatic logic [33:0] rec(input logic [1:0] k, input logic [7:0] p,
                                        input logic [7:0] i, input logic [7:0] a,
                                        input logic [7:0] v);
        return {k, p, i, a, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] p, input logic [7:0] i,
                                 input logic rw, input logic [7:0] wd, input logic mw,
                                 input logic [7:0] ma, input logic [7:0] md, input logic rdy);
        trace_en  = en;
        pc        = p;
        inst      = i;
        reg_write = rw;
        wdata_reg = wd;
        mem_write = mw;
        mem_addr  = ma;
        mem_wdata = md;
        ready     = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Mid-cycle reset pulse that ends before the next rising edge
    task automatic pulseReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [33:0] data34();
        return tif.trace_data[33:0];
    endfunction

    initial begin
        reset = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0);
        #12;
        checkOutput("reset_valid", 64'(tif.trace_valid), 64'd0);
        checkOutput("reset_data", 64'(data34()), 64'd0);
        checkOutput("reset_halted", 64'(halted), 64'd0);
        checkOutput("reset_ovf", 64'(overflow_cnt), 64'd0);
        checkOutput("reset_cycle", 64'(cycle_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Register-write record
        applyStimulus(1, 8'h05, 8'h4A, 1, 8'h3C, 0, 8'h00, 8'h00, 1);
        tick();
        checkOutput("regw_valid", 64'(tif.trace_valid), 64'd1);
        checkOutput("regw_data", 64'(data34()), 64'(34'h1_054A_003C));
        checkOutput("regw_cycle", 64'(cycle_count), 64'd1);
        applyStimulus(0, 8'h05, 8'h4A, 0, 8'h00, 0, 8'h00, 8'h00, 1);
        tick();
        checkOutput("regw_drained", 64'(tif.trace_valid), 64'd0);
        checkOutput("regw_cycle_hold", 64'(cycle_count), 64'd1);

        // Store wins over simultaneous register write
        applyStimulus(1, 8'h10, 8'hC2, 1, 8'h55, 1, 8'h20, 8'h7F, 0);
        tick();
        checkOutput("store_data", 64'(data34()), 64'(34'h2_10C2_207F));
        checkOutput("store_cycle", 64'(cycle_count), 64'd2);
        applyStimulus(0, 8'h10, 8'hC2, 0, 8'h00, 0, 8'h00, 8'h00, 1);
        tick();
        checkOutput("store_single", 64'(tif.trace_valid), 64'd0);

        // Backpressure and overflow: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'(8'h40 + i), 8'(i), 1, 8'(8'h80 + i), 0, 8'h00, 8'h00, 0);
            tick();
            if (i == 0) checkOutput("ovf_first", 64'(data34()), 64'(rec(2'b01, 8'h40, 8'h00, 8'h00, 8'h80)));
        end
        checkOutput("ovf_cnt", 64'(overflow_cnt), 64'd4);
        checkOutput("ovf_stable", 64'(data34()), 64'(rec(2'b01, 8'h40, 8'h00, 8'h00, 8'h80)));
        checkOutput("ovf_cycle", 64'(cycle_count), 64'd22);
        applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("drain_valid_%0d", i), 64'(tif.trace_valid), 64'd1);
            checkOutput($sformatf("drain_data_%0d", i), 64'(data34()),
                        64'(rec(2'b01, 8'(8'h40 + i), 8'(i), 8'h00, 8'(8'h80 + i))));
            tick();
        end
        checkOutput("drain_empty", 64'(tif.trace_valid), 64'd0);

        // Halt detection from a fresh reset
        pulseReset();
        checkOutput("rst2_ovf", 64'(overflow_cnt), 64'd0);
        checkOutput("rst2_cycle", 64'(cycle_count), 64'd0);
        applyStimulus(1, 8'h00, 8'h77, 0, 8'h00, 0, 8'h00, 8'h00, 1);
        tick();
        pc = 8'h01;
        tick();
        pc = 8'h02;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("halt_not_yet", 64'(halted), 64'd0);
        tick();
        checkOutput("halt_rise", 64'(halted), 64'd1);
        checkOutput("halt_cycle", 64'(cycle_count), 64'd7);
        applyStimulus(1, 8'h02, 8'h77, 1, 8'h99, 0, 8'h00, 8'h00, 0);
        tick();
        checkOutput("marker_valid", 64'(tif.trace_valid), 64'd1);
        checkOutput("marker_data", 64'(data34()), 64'(34'h3_0277_0700));
        tick();
        checkOutput("marker_hold", 64'(data34()), 64'(34'h3_0277_0700));
        ready = 1'b1;
        tick();
        checkOutput("marker_taken", 64'(tif.trace_valid), 64'd0);
        tick();
        tick();
        checkOutput("frozen_valid", 64'(tif.trace_valid), 64'd0);
        checkOutput("frozen_cycle", 64'(cycle_count), 64'd7);
        checkOutput("frozen_halted", 64'(halted), 64'd1);

        // Halt while the FIFO is full: marker waits behind 16 records
        pulseReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'(8'h60 + i), 8'(i), 1, 8'(i), 0, 8'h00, 8'h00, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h6F, 8'h0F, 1, 8'hEE, 0, 8'h00, 8'h00, 0);
            tick();
        end
        checkOutput("full_halted", 64'(halted), 64'd1);
        checkOutput("full_ovf", 64'(overflow_cnt), 64'd4);
        checkOutput("full_cycle", 64'(cycle_count), 64'd20);
        tick();
        checkOutput("full_head", 64'(data34()), 64'(rec(2'b01, 8'h60, 8'h00, 8'h00, 8'h00)));
        applyStimulus(0, 8'h6F, 8'h0F, 0, 8'h00, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("full_drain_%0d", i), 64'(data34()),
                        64'(rec(2'b01, 8'(8'h60 + i), 8'(i), 8'h00, 8'(i))));
            tick();
        end
        checkOutput("full_marker_valid", 64'(tif.trace_valid), 64'd1);
        checkOutput("full_marker_data", 64'(data34()), 64'(34'h3_6F0F_1404));
        tick();
        checkOutput("full_marker_last", 64'(tif.trace_valid), 64'd0);
        checkOutput("full_ovf_after", 64'(overflow_cnt), 64'd4);

        // Asynchronous reset while records are queued
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'(8'h90 + i), 8'h33, 1, 8'(i), 0, 8'h00, 8'h00, 0);
            tick();
        end
        checkOutput("areset_pre_valid", 64'(tif.trace_valid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("areset_valid", 64'(tif.trace_valid), 64'd0);
        checkOutput("areset_data", 64'(data34()), 64'd0);
        checkOutput("areset_cycle", 64'(cycle_count), 64'd0);
        checkOutput("areset_halted", 64'(halted), 64'd0);
        #1;
        reset = 1'b0;
        applyStimulus(1, 8'hA0, 8'h11, 1, 8'h22, 0, 8'h00, 8'h00, 0);
        tick();
        checkOutput("areset_fresh", 64'(data34()), 64'(34'h1_A011_0022));
        applyStimulus(0, 8'hA0, 8'h11, 0, 8'h00, 0, 8'h00, 8'h00, 1);
        tick();
        checkOutput("areset_no_old", 64'(tif.trace_valid), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/exec_trace_buffer.md
Name: exec_trace_buffer

Overview:
- Downstream consumer of the 8-bit single-cycle processor's debug outputs: PC, instruction, register write-back and store signals.
- Each cycle it converts architectural side effects (register writes, memory stores) into trace records and buffers them in a FIFO.
- Records drain over a valid/ready stream to a host or checker.
- Also detects program termination: PC held constant, e.g. a jump-to-self, for HALT_CYCLES consecutive cycles. On detection it emits a final halt marker and freezes capture.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- HALT_CYCLES, 4, consecutive equal-PC samples that declare halt; 1..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- trace_en  input  1  capture enable; when 0, nothing is captured and the halt/cycle counters hold.
- pc  input  8  current PC (processor PCout).
- inst  input  8  current instruction.
- reg_write  input  1  RegWrite.
- wdata_reg  input  8  register write-back data.
- mem_write  input  1  MemWrite.
- mem_addr  input  8  store address (ALUOut).
- mem_wdata  input  8  store data (ReadData2).
- trace_valid  output  1  a record is presented.
- trace_ready  input  1  consumer accepts the record.
- trace_data  output  34  record; 50 bits with the optional feature.
- halted  output  1  halt detected; sticky until reset.
- overflow_cnt  output  8  dropped records, saturating at 255.
- cycle_count  output  16  captured cycles, wrapping.

Behaviour:
- Reset values: trace_valid=0, trace_data=0, halted=0, overflow_cnt=0, cycle_count=0, FIFO empty, prev_pc_valid=0, stable_cnt=0, halt_pending=0.
- Record format: [33:32] kind, [31:24] pc, [23:16] inst, [15:8] addr, [7:0] value.
  - Kind 01, register write: addr=0, value=wdata_reg.
  - Kind 10, store: addr=mem_addr, value=mem_wdata.
  - Kind 11, halt marker: pc=halted PC, inst=inst, addr=cycle_count[7:0], value=overflow_cnt.
- Capture occurs in a cycle with trace_en=1 and halted=0.
  - mem_write=1 pushes a store record; otherwise reg_write=1 pushes a register-write record.
  - If both are asserted, only the store is recorded.
  - cycle_count increments by 1 and wraps 0xFFFF to 0.
- Latency: a record captured at edge N is visible on trace_valid/trace_data after edge N when the FIFO was empty.
  - Output is registered from the FIFO head; no combinational input-to-output path.
- Handshake:
  - A record transfers on an edge with trace_valid=1 and trace_ready=1.
  - trace_data is held stable while trace_valid=1 and trace_ready=0.
  - trace_valid never drops without a transfer, except on reset.
- Full FIFO:
  - A push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and overflow_cnt increments (saturating).
  - Simultaneous push and pop at count==DEPTH leaves count==DEPTH.
- Empty FIFO: trace_valid=0; trace_ready is ignored.
- Halt detection, evaluated only in capture cycles:
  - If prev_pc_valid=1 and pc==prev_pc, stable_cnt increments (saturating at HALT_CYCLES); otherwise stable_cnt clears to 0.
  - prev_pc is loaded with pc and prev_pc_valid is set to 1.
  - When stable_cnt reaches HALT_CYCLES, halt_pending is set and halted goes to 1 on that edge.
  - From then on, capture stops and cycle_count freezes.
- Halt marker:
  - While halt_pending=1, the marker is pushed on the first cycle with space; a same-cycle pop counts as space.
  - halt_pending then clears.
  - The marker is never dropped and never counted in overflow_cnt.
  - Exactly one marker is emitted per reset.
- Reset mid-operation: FIFO contents are discarded and any in-flight record is lost; trace_valid falls asynchronously.

Optional Feature:
- Macro: TRACE_CYCLE_STAMP_EN.
- Defined: trace_data is 50 bits, with [49:34] = cycle_count value at the capture edge, i.e. before its increment. Halt marker stamp = frozen cycle_count.
- Undefined: trace_data is 34 bits and the stamp logic is absent.

Test Plan:
- Register-write record: reset, trace_en=1, pc=0x05, inst=0x4A, reg_write=1, wdata_reg=0x3C, trace_ready=1 for one cycle → one record 34'h1_054A_003C; cycle_count=1.
- Store priority: pc=0x10, inst=0xC2, mem_write=1, reg_write=1, mem_addr=0x20, mem_wdata=0x7F → single record 34'h2_10C2_207F; no register-write record.
- Backpressure/overflow (DEPTH=16): trace_ready=0, 20 consecutive reg_write cycles → FIFO holds the first 16, overflow_cnt=4, trace_data stable. Then trace_ready=1 → 16 records drain in order, one per cycle.
- Halt detection (HALT_CYCLES=4): pc sequence 0x00,0x01,0x02,0x02,0x02,0x02,0x02 with trace_en=1 → halted rises at the 7th edge. Marker kind 11, pc=0x02, addr=0x07, value=0x00. Further reg_write pulses produce nothing and cycle_count stays 7.
- Halt marker with full FIFO: FIFO full, trace_ready=0, halt condition met → halted=1, no marker yet. Raise trace_ready → after the 16 queued records drain, the marker is the 17th; overflow_cnt is unchanged by the marker.
- Asynchronous reset mid-drain: assert reset between clock edges while trace_valid=1 with 5 records queued → trace_valid, halted and all counters go to 0 immediately, without waiting for a clock edge. The first capture after release produces a fresh record, and the old records never appear.
